// File: rtl/bus_arbit_pkg.sv
// +----------------------------------------------------------------------+
// | bus_arbit_pkg : shared constants and state encoding for bus_rr_arbit   |
// | Revision      : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package bus_arbit_pkg;

  localparam int N_MASTERS        = 4;
  localparam int MAX_HOLD_DEFAULT = 8;
  localparam int HOLD_CNT_W       = 8;

  // One state per master; the encoding equals the granted master index.
  typedef enum logic [1:0] {
    GRANT0 = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2,
    GRANT3 = 2'd3
  } state_t;

endpackage : bus_arbit_pkg

`default_nettype wire

// File: rtl/bus_rr_arbit_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick  : first requester after cur in cyclic order cur+1..cur+3      |
// | Revision : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import bus_arbit_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] cur,
  output logic [1:0] next_idx,
  output logic       valid
);

  logic [1:0] cand;

  // Walk farthest-first so the nearest requester overwrites and wins.
  always_comb begin
    next_idx = cur;
    valid    = 1'b0;
    cand     = cur;
    for (int k = N_MASTERS - 1; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (req[cand]) begin
        next_idx = cand;
        valid    = 1'b1;
      end
    end
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/bus_rr_arbit.sv
// +----------------------------------------------------------------------+
// | bus_rr_arbit : 4-master round-robin Moore bus arbiter with hold count  |
// | Optional hold-limit preemption: define BUS_ARBIT_HOLD_LIMIT_EN         |
// | Revision     : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_rr_arbit
  import bus_arbit_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] m_req,
  output logic [3:0] m_grant,
  output logic [1:0] cur_master,
  output logic [7:0] hold_cnt
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_SAT  = '1;

  state_t                  state_q;
  state_t                  state_d;
  logic [HOLD_CNT_W-1:0]   hold_q;
  logic [HOLD_CNT_W-1:0]   hold_d;
  logic                    own_req;
  logic [1:0]              pick_idx;
  logic                    pick_valid;
  logic                    limit_en;
  logic                    limit_hit;

`ifdef BUS_ARBIT_HOLD_LIMIT_EN
  assign limit_en = 1'b1;
`else
  assign limit_en = 1'b0;
`endif

  rr_pick u_rr_pick (
    .req      (m_req),
    .cur      (state_q),
    .next_idx (pick_idx),
    .valid    (pick_valid)
  );

  assign own_req = m_req[state_q];

  // ">=" rather than "==" so an owner that ran alone past the limit still
  // yields as soon as a competitor shows up.
  assign limit_hit = limit_en & own_req & pick_valid & (hold_q >= HOLD_LAST);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (own_req)
      1'b1:    if (limit_hit)  state_d = state_t'(pick_idx);
      1'b0:    if (pick_valid) state_d = state_t'(pick_idx);
      default: state_d = state_t'(2'bxx);
    endcase
    if (state_d != state_q) begin
      hold_d = '0;
    end else if (own_req) begin
      hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= GRANT0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign m_grant    = 4'b0001 << state_q;
  assign cur_master = state_q;
  assign hold_cnt   = hold_q;

endmodule : bus_rr_arbit

`default_nettype wire

// File: tb/tb_bus_rr_arbit.sv
// +----------------------------------------------------------------------+
// | tb_bus_rr_arbit : directed + random self-checking bench for arbiter    |
// | Revision        : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bus_rr_arbit;

  localparam int MAX_HOLD = 8;

`ifdef BUS_ARBIT_HOLD_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] m_req;
  logic [3:0] m_grant;
  logic [1:0] cur_master;
  logic [7:0] hold_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index and consecutive-cycle count as integers.
  int mdl_owner;
  int mdl_cnt;

  bus_rr_arbit #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m_req      (m_req),
    .m_grant    (m_grant),
    .cur_master (cur_master),
    .hold_cnt   (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] req);
    int  nxt;
    bit  own;
    bit  others;
    own    = req[mdl_owner];
    others = (req & ~(4'b0001 << mdl_owner)) != 4'b0000;
    nxt    = mdl_owner;
    if (!own || (LIMIT_ON && others && mdl_cnt >= MAX_HOLD - 1)) begin
      for (int k = 3; k >= 1; k--)
        if (req[(mdl_owner + k) % 4]) nxt = (mdl_owner + k) % 4;
    end
    if (nxt != mdl_owner) mdl_cnt = 0;
    else if (own)         mdl_cnt = (mdl_cnt + 1 > 255) ? 255 : mdl_cnt + 1;
    mdl_owner = nxt;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".grant"}, 32'(m_grant), 32'(1 << mdl_owner));
    chk({tag, ".cur"},   32'(cur_master), 32'(mdl_owner));
    chk({tag, ".hold"},  32'(hold_cnt), 32'(mdl_cnt));
  endtask

  // Advance one clock with the current m_req, then sample 1 time unit later.
  task automatic tick(input string tag);
    model_step(m_req);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    m_req     = 4'b1111;
    mdl_owner = 0;
    mdl_cnt   = 0;

    // Reset with all masters requesting.
    #1;
    chk("rst_async.grant", 32'(m_grant), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.grant", 32'(m_grant), 32'h1);
    chk("rst.cur",   32'(cur_master), 32'h0);
    chk("rst.hold",  32'(hold_cnt), 32'h0);
    m_req   = 4'b0000;
    reset_n = 1'b1;

    // Single handoff and parking.
    m_req = 4'b0100;
    tick("handoff");
    chk("handoff.grant", 32'(m_grant), 32'h4);
    chk("handoff.cur",   32'(cur_master), 32'h2);
    m_req = 4'b0000;
    tick("park");
    chk("park.grant", 32'(m_grant), 32'h4);

    // Rotation from master 1 skips past master 0 to master 3.
    m_req = 4'b0010;
    tick("to1");
    chk("to1.grant", 32'(m_grant), 32'h2);
    m_req = 4'b1001;
    tick("rot");
    chk("rot.grant", 32'(m_grant), 32'h8);

    // Hold-limit behaviour with master 0 and master 1 competing.
    m_req = 4'b0001;
    tick("to0");
    chk("to0.hold", 32'(hold_cnt), 32'h0);
    m_req = 4'b0011;
    if (LIMIT_ON) begin
      repeat (MAX_HOLD - 1) tick("lim");
      chk("lim.before", 32'(m_grant), 32'h1);
      tick("lim");
      chk("lim.after.grant", 32'(m_grant), 32'h2);
      chk("lim.after.hold",  32'(hold_cnt), 32'h0);
    end else begin
      repeat (300) tick("nolim");
      chk("nolim.grant", 32'(m_grant), 32'h1);
      chk("nolim.hold",  32'(hold_cnt), 32'd255);
    end

    // Mid-grant asynchronous reset while master 3 holds with count 5.
    m_req = 4'b1000;
    tick("to3");
    repeat (5) tick("cnt3");
    chk("mid.pre.grant", 32'(m_grant), 32'h8);
    chk("mid.pre.hold",  32'(hold_cnt), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid.grant", 32'(m_grant), 32'h1);
    chk("mid.hold",  32'(hold_cnt), 32'h0);
    chk("mid.cur",   32'(cur_master), 32'h0);
    mdl_owner = 0;
    mdl_cnt   = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // First edge after release evaluates normally.
    m_req = 4'b0010;
    tick("post_rst");
    chk("post_rst.grant", 32'(m_grant), 32'h2);

    // A lone requester is never preempted, long past the hold limit.
    m_req = 4'b0100;
    repeat (20) tick("alone");
    chk("alone.grant", 32'(m_grant), 32'h4);
    chk("alone.hold",  32'(hold_cnt), 32'd19);

    // Random bursts: each pattern held for 1..12 cycles to reach limits.
    for (int b = 0; b < 80; b++) begin
      m_req = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bus_rr_arbit

`default_nettype wire

// File: doc/bus_rr_arbit.md
BUS_RR_ARBIT -- requirements
Module: bus_rr_arbit

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles a master holds the grant while another master waits; the legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port m_req, input, 4 bits: bit i is the bus request of master i.
REQ-005 The block SHALL have port m_grant, output, 4 bits: a one-hot bus grant, with bit i granting master i.
REQ-006 The block SHALL have port cur_master, output, 2 bits: the binary index of the granted master.
REQ-007 The block SHALL have port hold_cnt, output, 8 bits: the consecutive-cycle count of the current grant.

Function
REQ-008 The block SHALL implement a Moore FSM with four states, GRANT0..GRANT3; exactly one m_grant bit is high in every state (the bus is parked, never ungranted).
REQ-009 m_grant and cur_master SHALL decode from the state register only; no combinational path from m_req to m_grant is allowed.
REQ-010 The state SHALL change only on a rising clk edge, so a request change is reflected in m_grant after the first edge following it (1-cycle latency).
REQ-011 In GRANTi with m_req[i]=1 and the hold limit not reached (REQ-015), the FSM SHALL stay in GRANTi.
REQ-012 In GRANTi with m_req[i]=0 and any other request high, the FSM SHALL move to the first requesting master in round-robin order i+1, i+2, i+3 (mod 4).
REQ-013 In GRANTi with m_req=0000, the FSM SHALL stay in GRANTi (park on the last owner).
REQ-014 hold_cnt SHALL behave as follows:
- clears to 0 on every state change;
- increments by 1 per cycle in GRANTi while m_req[i]=1;
- saturates at 255;
- holds its value while m_req[i]=0 and no state change occurs.
REQ-015 The hold limit is reached when hold_cnt = MAX_HOLD-1, m_req[i]=1 and another request is high; under BUS_ARBIT_HOLD_LIMIT_EN the FSM SHALL then switch per REQ-012 ordering.
REQ-016 A master requesting alone SHALL never be preempted, whatever the hold_cnt value.
REQ-017 Simultaneous requests at a switch point SHALL resolve by REQ-012 rotation, never by fixed priority, so no master waits more than 3 grant periods.
REQ-018 X/Z on m_req SHALL drive next state to X in simulation (no silent default).

Reset
REQ-019 reset_n=0 SHALL immediately, without a clock, force state GRANT0, m_grant=0001, cur_master=0 and hold_cnt=0.
REQ-020 Reset asserted mid-grant SHALL abort the current ownership with no drain.
REQ-021 The first edge after reset_n rises SHALL evaluate REQ-011..REQ-015 normally.

Configuration
REQ-022 The macro BUS_ARBIT_HOLD_LIMIT_EN SHALL control the hold limit:
- defined: REQ-015 preemption is active;
- undefined: REQ-015 never fires, the owner keeps the grant while m_req[i]=1, and hold_cnt still counts per REQ-014.

Structure
REQ-023 Shared package bus_arbit_pkg SHALL hold:
- the state encoding localparams GRANT0..GRANT3 (2-bit binary);
- the master count constant N_MASTERS=4;
- the MAX_HOLD default.
REQ-024 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: 4-bit request and 2-bit current index; outputs: 2-bit next index and valid), instantiated once.

Verification
REQ-025 Reset: hold reset_n=0 with m_req=1111, then release -> m_grant=0001 while in reset; hold_cnt=0.
REQ-026 Single handoff: from GRANT0 apply m_req=0100 -> after 1 edge m_grant=0100 and cur_master=2; then m_req=0000 -> m_grant stays 0100.
REQ-027 Rotation: in GRANT1 drop m_req[1] with m_req=1001 -> next grant is 1000 (master 3), not master 0.
REQ-028 Hold limit (macro defined, MAX_HOLD=8): master 0 owns the bus, then m_req=0011 is held constant -> m_grant=0001 for exactly 8 cycles, then 0010, with hold_cnt=0 after the switch.
REQ-029 Hold limit off (macro undefined), same stimulus -> m_grant stays 0001 for 300 cycles and hold_cnt saturates at 255.
REQ-030 Mid-grant reset: assert reset_n=0 asynchronously while in GRANT3 with hold_cnt=5 -> m_grant=0001 and hold_cnt=0 before the next clk edge.
